// File: rtl/tank_pkg.sv
// Shared tank-game types: headings, bullet FSM states, screen limits and
// the heading-to-velocity lookup used by the projectile engine.
package tank_pkg;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  typedef enum logic [2:0] {
    DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
  } dir_t;

  typedef enum logic [1:0] {IDLE, SPAWN, FLY, COOLDOWN} bc_state_t;

  typedef struct packed {
    logic signed [10:0] vx;
    logic signed [10:0] vy;
  } vel_t;

  // Screen Y grows downwards, so north is negative vy.
  function automatic vel_t dir_to_vel(dir_t dir, int speed);
    vel_t v;
    logic signed [10:0] s;
    s    = 11'(speed);
    v.vx = '0;
    v.vy = '0;
    case (dir)
      DIR_N:  v.vy = -s;
      DIR_NE: begin v.vx = s;  v.vy = -s; end
      DIR_E:  v.vx = s;
      DIR_SE: begin v.vx = s;  v.vy = s;  end
      DIR_S:  v.vy = s;
      DIR_SW: begin v.vx = -s; v.vy = s;  end
      DIR_W:  v.vx = -s;
      DIR_NW: begin v.vx = -s; v.vy = -s; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic signed [11:0] clamp_axis(logic signed [11:0] v,
                                                    logic signed [11:0] lo,
                                                    logic signed [11:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/bullet_controller_if.sv
// Tank-side inputs and color_mapper-side outputs of one bullet engine.
interface bullet_controller_if;
  logic       frame_clk;
  logic       fire;
  logic [9:0] tank_x;
  logic [9:0] tank_y;
  logic [2:0] tank_dir;
  logic       barrier_hit_x;
  logic       barrier_hit_y;
  logic       target_hit;
  logic [9:0] BulletX;
  logic [9:0] BulletY;
  logic [9:0] Bullet_Size;
  logic       bullet_on;
  logic       fire_ack;
  logic       busy;

  modport master (
    output frame_clk, fire, tank_x, tank_y, tank_dir,
           barrier_hit_x, barrier_hit_y, target_hit,
    input  BulletX, BulletY, Bullet_Size, bullet_on, fire_ack, busy
  );

  modport slave (
    input  frame_clk, fire, tank_x, tank_y, tank_dir,
           barrier_hit_x, barrier_hit_y, target_hit,
    output BulletX, BulletY, Bullet_Size, bullet_on, fire_ack, busy
  );
endinterface

// File: rtl/frame_tick_detect.sv
// Brings vsync into the Clk domain and emits a registered 1-cycle tick
// three cycles after each rising edge.
module frame_tick_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);
  logic sync1, sync2, sync3;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      sync3 <= sync2;
      tick  <= sync2 & ~sync3;
    end
  end
endmodule

// File: rtl/bullet_controller.sv
// Single-bullet projectile engine: spawn at the barrel tip, fly one step per
// frame with edge/barrier reflection, retire on hit, age or bounce budget.
module bullet_controller
  import tank_pkg::*;
#(
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479,
  parameter int BULLET_SIZE     = 4,
  parameter int SPEED           = 4,
  parameter int BARREL_OFFSET   = 20,
  parameter int LIFETIME_FRAMES = 240,
  parameter int MAX_BOUNCES     = 3,
  parameter int COOLDOWN_FRAMES = 30
) (
  input logic               Clk,
  input logic               Reset,
  bullet_controller_if.slave bus
);
  localparam logic signed [11:0] LO   = 12'(BULLET_SIZE);
  localparam logic signed [11:0] X_HI = 12'(X_MAX - BULLET_SIZE);
  localparam logic signed [11:0] Y_HI = 12'(Y_MAX - BULLET_SIZE);
  localparam logic signed [11:0] OFF  = 12'(BARREL_OFFSET);

  bc_state_t          state, state_n;
  logic [9:0]         bx, by, bx_n, by_n;
  logic signed [10:0] vx, vy, vx_n, vy_n;
  logic               rx, ry, rx_n, ry_n;
  logic [15:0]        bounce_cnt, bounce_n, life_cnt, life_n, cd_cnt, cd_n;
  logic               on, on_n, ack, ack_n;
  logic               fire_q, fire_edge, tick;

  vel_t               vel;
  logic signed [11:0] sx, sy, nx, ny;
  logic               hit_x, hit_y, kill;

  frame_tick_detect u_tick (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(bus.frame_clk),
    .tick     (tick)
  );

  assign fire_edge = bus.fire & ~fire_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      bx         <= '0;
      by         <= '0;
      vx         <= '0;
      vy         <= '0;
      rx         <= 1'b0;
      ry         <= 1'b0;
      bounce_cnt <= '0;
      life_cnt   <= '0;
      cd_cnt     <= '0;
      on         <= 1'b0;
      ack        <= 1'b0;
      fire_q     <= 1'b0;
    end else begin
      state      <= state_n;
      bx         <= bx_n;
      by         <= by_n;
      vx         <= vx_n;
      vy         <= vy_n;
      rx         <= rx_n;
      ry         <= ry_n;
      bounce_cnt <= bounce_n;
      life_cnt   <= life_n;
      cd_cnt     <= cd_n;
      on         <= on_n;
      ack        <= ack_n;
      fire_q     <= bus.fire;
    end
  end

  always_comb begin
    state_n  = state;
    bx_n     = bx;
    by_n     = by;
    vx_n     = vx;
    vy_n     = vy;
    rx_n     = rx;
    ry_n     = ry;
    bounce_n = bounce_cnt;
    life_n   = life_cnt;
    cd_n     = cd_cnt;
    on_n     = on;
    ack_n    = 1'b0;
    kill     = 1'b0;

    vel = dir_to_vel(dir_t'(bus.tank_dir), SPEED);
    sx  = $signed({2'b00, bus.tank_x});
    sy  = $signed({2'b00, bus.tank_y});
    if (vx != '0) sx = vx[10] ? sx - OFF : sx + OFF;
    if (vy != '0) sy = vy[10] ? sy - OFF : sy + OFF;
    sx = clamp_axis(sx, LO, X_HI);
    sy = clamp_axis(sy, LO, Y_HI);

    // A barrier pulse arriving on the tick cycle itself is honoured at once.
    nx    = $signed({2'b00, bx}) + $signed({vx[10], vx});
    ny    = $signed({2'b00, by}) + $signed({vy[10], vy});
    hit_x = rx | bus.barrier_hit_x | (nx < LO) | (nx > X_HI);
    hit_y = ry | bus.barrier_hit_y | (ny < LO) | (ny > Y_HI);

    case (state)
      IDLE: begin
        if (fire_edge) begin
          vx_n    = vel.vx;
          vy_n    = vel.vy;
          ack_n   = 1'b1;
          state_n = SPAWN;
        end
      end
      SPAWN: begin
        bx_n     = 10'(sx);
        by_n     = 10'(sy);
        on_n     = 1'b1;
        bounce_n = '0;
        life_n   = '0;
        state_n  = FLY;
      end
      FLY: begin
        if (bus.barrier_hit_x) rx_n = 1'b1;
        if (bus.barrier_hit_y) ry_n = 1'b1;
        if (bus.target_hit) begin
          kill = 1'b1;
        end else if (tick) begin
          life_n = life_cnt + 16'd1;
          rx_n   = 1'b0;
          ry_n   = 1'b0;
          if (hit_x) vx_n = -vx; else bx_n = 10'(nx);
          if (hit_y) vy_n = -vy; else by_n = 10'(ny);
          if (hit_x || hit_y) begin
            if (bounce_cnt == 16'(MAX_BOUNCES)) kill = 1'b1;
            else bounce_n = bounce_cnt + 16'd1;
          end
          if (life_n == 16'(LIFETIME_FRAMES)) kill = 1'b1;
        end
        if (kill) begin
          on_n    = 1'b0;
          bx_n    = bx;
          by_n    = by;
          rx_n    = 1'b0;
          ry_n    = 1'b0;
          cd_n    = '0;
          state_n = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (COOLDOWN_FRAMES == 0) begin
          state_n = IDLE;
        end else if (tick) begin
          cd_n = cd_cnt + 16'd1;
          if (cd_n == 16'(COOLDOWN_FRAMES)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.BulletX     = bx;
  assign bus.BulletY     = by;
  assign bus.Bullet_Size = 10'(BULLET_SIZE);
  assign bus.bullet_on   = on;
  assign bus.fire_ack    = ack;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_bullet_controller.sv
// Directed self-checking bench for bullet_controller: spawn, flight, edge and
// corner reflection, bounce/target retirement, cooldown, held fire, reset.
module tb_bullet_controller;
  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   ack_cnt = 0;

  bullet_controller_if bif ();

  bullet_controller #(
    .X_MAX          (639),
    .Y_MAX          (479),
    .BULLET_SIZE    (4),
    .SPEED          (4),
    .BARREL_OFFSET  (20),
    .LIFETIME_FRAMES(240),
    .MAX_BOUNCES    (3),
    .COOLDOWN_FRAMES(30)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bif)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    #1;
    if (bif.fire_ack === 1'b1) ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // One vsync period; the tick is consumed on the 4th rising Clk edge.
  task automatic do_frame();
    bif.frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    bif.frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic pulse_reset(input logic [9:0] tx, input logic [9:0] ty, input logic [2:0] dir);
    Reset = 1'b1;
    bif.fire = 1'b0;
    bif.tank_x = tx;
    bif.tank_y = ty;
    bif.tank_dir = dir;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic launch();
    bif.fire = 1'b1;
    @(negedge Clk);
    bif.fire = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (bif.BulletX !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d required 0", bif.BulletX); end
    checks++; if (bif.BulletY !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d required 0", bif.BulletY); end
    checks++; if (bif.bullet_on !== 1'b0) begin errors++; $display("FAIL reset_on: got %b required 0", bif.bullet_on); end
    checks++; if (bif.fire_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", bif.fire_ack); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bif.busy); end
    checks++; if (bif.Bullet_Size !== 10'd4) begin errors++; $display("FAIL size: got %0d required 4", bif.Bullet_Size); end
    Reset = 1'b0;
  endtask

  task automatic test_fire_east();
    pulse_reset(10'd320, 10'd240, 3'd2);
    bif.fire = 1'b1;
    @(negedge Clk);
    checks++; if (bif.fire_ack !== 1'b1) begin errors++; $display("FAIL fire_ack: got %b required 1", bif.fire_ack); end
    checks++; if (bif.bullet_on !== 1'b0) begin errors++; $display("FAIL spawn_early_on: got %b required 0", bif.bullet_on); end
    checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL spawn_busy: got %b required 1", bif.busy); end
    bif.fire = 1'b0;
    @(negedge Clk);
    checks++; if (bif.fire_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b required 0", bif.fire_ack); end
    checks++; if (bif.bullet_on !== 1'b1) begin errors++; $display("FAIL spawn_on: got %b required 1", bif.bullet_on); end
    checks++; if (bif.BulletX !== 10'd340 || bif.BulletY !== 10'd240) begin errors++; $display("FAIL spawn_pos: got (%0d,%0d) required (340,240)", bif.BulletX, bif.BulletY); end
    repeat (3) do_frame();
    checks++; if (bif.BulletX !== 10'd352 || bif.BulletY !== 10'd240) begin errors++; $display("FAIL fly_3: got (%0d,%0d) required (352,240)", bif.BulletX, bif.BulletY); end
  endtask

  task automatic test_right_edge();
    pulse_reset(10'd612, 10'd240, 3'd2);
    launch();
    checks++; if (bif.BulletX !== 10'd632) begin errors++; $display("FAIL edge_spawn: got %0d required 632", bif.BulletX); end
    do_frame();
    checks++; if (bif.BulletX !== 10'd632 || bif.bullet_on !== 1'b1) begin errors++; $display("FAIL edge_hold: got x=%0d on=%b required x=632 on=1", bif.BulletX, bif.bullet_on); end
    do_frame();
    checks++; if (bif.BulletX !== 10'd628) begin errors++; $display("FAIL edge_back1: got %0d required 628", bif.BulletX); end
    do_frame();
    checks++; if (bif.BulletX !== 10'd624 || bif.BulletY !== 10'd240) begin errors++; $display("FAIL edge_back2: got (%0d,%0d) required (624,240)", bif.BulletX, bif.BulletY); end
  endtask

  task automatic test_corner_bounces();
    pulse_reset(10'd614, 10'd26, 3'd1);
    launch();
    checks++; if (bif.BulletX !== 10'd634 || bif.BulletY !== 10'd6) begin errors++; $display("FAIL corner_spawn: got (%0d,%0d) required (634,6)", bif.BulletX, bif.BulletY); end
    do_frame();
    checks++; if (bif.BulletX !== 10'd634 || bif.BulletY !== 10'd6 || bif.bullet_on !== 1'b1) begin errors++; $display("FAIL corner_hold: got (%0d,%0d) on=%b required (634,6) on=1", bif.BulletX, bif.BulletY, bif.bullet_on); end
    for (int i = 0; i < 2; i++) begin
      bif.barrier_hit_x = 1'b1;
      @(negedge Clk);
      bif.barrier_hit_x = 1'b0;
      do_frame();
      checks++; if (bif.BulletX !== 10'd634 || bif.BulletY !== 10'(10 + 4 * i) || bif.bullet_on !== 1'b1) begin errors++; $display("FAIL barrier_%0d: got (%0d,%0d) on=%b required (634,%0d) on=1", i, bif.BulletX, bif.BulletY, bif.bullet_on, 10 + 4 * i); end
    end
    do_frame();
    checks++; if (bif.BulletX !== 10'd630 || bif.BulletY !== 10'd18 || bif.bullet_on !== 1'b1) begin errors++; $display("FAIL free_move: got (%0d,%0d) on=%b required (630,18) on=1", bif.BulletX, bif.BulletY, bif.bullet_on); end
    bif.barrier_hit_x = 1'b1;
    @(negedge Clk);
    bif.barrier_hit_x = 1'b0;
    do_frame();
    checks++; if (bif.bullet_on !== 1'b0 || bif.busy !== 1'b1) begin errors++; $display("FAIL bounce_kill: got on=%b busy=%b required on=0 busy=1", bif.bullet_on, bif.busy); end
    checks++; if (bif.BulletX !== 10'd630 || bif.BulletY !== 10'd18) begin errors++; $display("FAIL kill_hold: got (%0d,%0d) required (630,18)", bif.BulletX, bif.BulletY); end
  endtask

  task automatic test_target_hit_cooldown();
    int a0;
    pulse_reset(10'd320, 10'd240, 3'd4);
    launch();
    checks++; if (bif.BulletX !== 10'd320 || bif.BulletY !== 10'd260) begin errors++; $display("FAIL south_spawn: got (%0d,%0d) required (320,260)", bif.BulletX, bif.BulletY); end
    do_frame();
    checks++; if (bif.BulletY !== 10'd264) begin errors++; $display("FAIL south_move: got %0d required 264", bif.BulletY); end
    bif.frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    bif.target_hit = 1'b1;
    @(negedge Clk);
    bif.target_hit = 1'b0;
    checks++; if (bif.bullet_on !== 1'b0 || bif.busy !== 1'b1) begin errors++; $display("FAIL hit_kill: got on=%b busy=%b required on=0 busy=1", bif.bullet_on, bif.busy); end
    checks++; if (bif.BulletX !== 10'd320 || bif.BulletY !== 10'd264) begin errors++; $display("FAIL hit_nomove: got (%0d,%0d) required (320,264)", bif.BulletX, bif.BulletY); end
    repeat (2) @(negedge Clk);
    bif.frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    a0 = ack_cnt;
    for (int k = 0; k < 30; k++) begin
      launch();
      do_frame();
    end
    checks++; if (ack_cnt !== a0) begin errors++; $display("FAIL cooldown_reject: got %0d acks required 0", ack_cnt - a0); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL cooldown_done: got busy=%b required 0", bif.busy); end
    bif.fire = 1'b1;
    @(negedge Clk);
    checks++; if (bif.fire_ack !== 1'b1) begin errors++; $display("FAIL refire_ack: got %b required 1", bif.fire_ack); end
    bif.fire = 1'b0;
    @(negedge Clk);
    checks++; if (bif.bullet_on !== 1'b1 || bif.BulletY !== 10'd260) begin errors++; $display("FAIL refire_spawn: got on=%b y=%0d required on=1 y=260", bif.bullet_on, bif.BulletY); end
  endtask

  task automatic test_held_fire();
    int a0;
    pulse_reset(10'd320, 10'd240, 3'd6);
    bif.fire = 1'b1;
    @(negedge Clk);
    checks++; if (bif.fire_ack !== 1'b1) begin errors++; $display("FAIL held_ack: got %b required 1", bif.fire_ack); end
    @(negedge Clk);
    checks++; if (bif.BulletX !== 10'd300 || bif.bullet_on !== 1'b1) begin errors++; $display("FAIL west_spawn: got x=%0d on=%b required x=300 on=1", bif.BulletX, bif.bullet_on); end
    bif.target_hit = 1'b1;
    @(negedge Clk);
    bif.target_hit = 1'b0;
    a0 = ack_cnt;
    repeat (31) do_frame();
    checks++; if (ack_cnt !== a0 || bif.busy !== 1'b0) begin errors++; $display("FAIL held_norepeat: got acks=%0d busy=%b required acks=0 busy=0", ack_cnt - a0, bif.busy); end
    bif.fire = 1'b0;
    @(negedge Clk);
    bif.fire = 1'b1;
    @(negedge Clk);
    checks++; if (bif.fire_ack !== 1'b1) begin errors++; $display("FAIL held_refire: got %b required 1", bif.fire_ack); end
    bif.fire = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_midflight_reset();
    pulse_reset(10'd100, 10'd100, 3'd3);
    launch();
    do_frame();
    checks++; if (bif.BulletX !== 10'd124 || bif.BulletY !== 10'd124) begin errors++; $display("FAIL se_move: got (%0d,%0d) required (124,124)", bif.BulletX, bif.BulletY); end
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (bif.bullet_on !== 1'b0 || bif.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got on=%b busy=%b required 0 0", bif.bullet_on, bif.busy); end
    checks++; if (bif.BulletX !== 10'd0 || bif.BulletY !== 10'd0) begin errors++; $display("FAIL mid_reset_pos: got (%0d,%0d) required (0,0)", bif.BulletX, bif.BulletY); end
    Reset = 1'b0;
    bif.fire = 1'b1;
    @(negedge Clk);
    checks++; if (bif.fire_ack !== 1'b1) begin errors++; $display("FAIL post_reset_ack: got %b required 1", bif.fire_ack); end
    bif.fire = 1'b0;
    @(negedge Clk);
    checks++; if (bif.BulletX !== 10'd120 || bif.BulletY !== 10'd120 || bif.bullet_on !== 1'b1) begin errors++; $display("FAIL post_reset_spawn: got (%0d,%0d) on=%b required (120,120) on=1", bif.BulletX, bif.BulletY, bif.bullet_on); end
  endtask

  initial begin
    bif.frame_clk     = 1'b0;
    bif.fire          = 1'b0;
    bif.tank_x        = '0;
    bif.tank_y        = '0;
    bif.tank_dir      = '0;
    bif.barrier_hit_x = 1'b0;
    bif.barrier_hit_y = 1'b0;
    bif.target_hit    = 1'b0;
    @(negedge Clk);
    test_reset();
    test_fire_east();
    test_right_edge();
    test_corner_bounces();
    test_target_hit_cooldown();
    test_held_fire();
    test_midflight_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
